// File: rtl/led_modes_pkg.sv
// ---------------------------------------------------------------------------
// led_modes_pkg
// Shared types and helpers for the LED mode sequencer.
//   mode_t         : the six display modes, SHIFTER=0 .. PINGPONG=5
//   NUM_MODES      : number of modes
//   MAX_LED_W      : widest LED bank the pattern helper can describe
//   entry_pattern  : pattern loaded into the LED bank when a mode is entered
//   next_mode /
//   prev_mode      : cyclic mode stepping in both directions
// ---------------------------------------------------------------------------
package led_modes_pkg;

    typedef enum logic [2:0] {
        SHIFTER  = 3'd0,
        COUNTER  = 3'd1,
        FIVES    = 3'd2,
        BLINK    = 3'd3,
        INV_CNT  = 3'd4,
        PINGPONG = 3'd5
    } mode_t;

    localparam int NUM_MODES = 6;
    localparam int MAX_LED_W = 64;

    // Returned wide; callers truncate to their own LED width.
    function automatic logic [MAX_LED_W-1:0] entry_pattern(input mode_t m, input int width);
        logic [MAX_LED_W-1:0] p;
        p = '0;
        for (int i = 0; i < MAX_LED_W; i++) begin
            unique case (m)
                SHIFTER:         p[i] = (i < (width / 2 + 1));
                FIVES:           p[i] = (i < width) && ((i % 2) == 0);
                BLINK, INV_CNT:  p[i] = (i < width);
                PINGPONG:        p[i] = (i == 0);
                default:         p[i] = 1'b0;
            endcase
        end
        return p;
    endfunction

    function automatic mode_t next_mode(input mode_t m);
        if (m == mode_t'(3'(NUM_MODES - 1))) return SHIFTER;
        return mode_t'(m + 3'd1);
    endfunction

    function automatic mode_t prev_mode(input mode_t m);
        if (m == SHIFTER) return mode_t'(3'(NUM_MODES - 1));
        return mode_t'(m - 3'd1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Raw button conditioning: 2-flop synchroniser, level debouncer and a
// one-cycle press pulse on each accepted 0->1 level change.
// Optional autorepeat (macro BTN_AUTOREPEAT_EN): while the debounced level
// stays high, a further pulse is issued CLK_FREQ cycles after the first one
// and then every CLK_FREQ/4 cycles.
// Ports:
//   clk_i    system clock
//   rst_n_i  synchronous active-low reset
//   btn_i    raw asynchronous button, active-high
//   press_o  registered one-cycle press pulse
// ---------------------------------------------------------------------------
module btn_debounce #(
`ifdef BTN_AUTOREPEAT_EN
    parameter int CLK_FREQ        = 25_000_000,
`endif
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic            sync1_q, sync2_q;
    logic [DB_W-1:0] db_cnt_q;
    logic            stable_q, stable_dly_q;
    logic            press_q;
    logic            rise_c, rep_hit_c;

    assign rise_c = stable_q & ~stable_dly_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            db_cnt_q     <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            // Any sample agreeing with the accepted level restarts the count.
            if (sync2_q != stable_q) begin
                if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable_q <= sync2_q;
                    db_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + DB_W'(1);
                end
            end else begin
                db_cnt_q <= '0;
            end
            stable_dly_q <= stable_q;
            press_q      <= rise_c | rep_hit_c;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RP_W = $clog2(CLK_FREQ + 1);

    logic [RP_W-1:0] rep_cnt_q;
    logic            repeating_q;

    // rep_cnt_q equals the number of cycles since the last emitted pulse.
    assign rep_hit_c = stable_q &&
        (rep_cnt_q == (repeating_q ? RP_W'(CLK_FREQ / 4) : RP_W'(CLK_FREQ)));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || !stable_q) begin
            rep_cnt_q   <= '0;
            repeating_q <= 1'b0;
        end else if (rep_hit_c) begin
            rep_cnt_q   <= RP_W'(1);
            repeating_q <= 1'b1;
        end else begin
            rep_cnt_q   <= rep_cnt_q + RP_W'(1);
        end
    end
`else
    assign rep_hit_c = 1'b0;
`endif

    assign press_o = press_q;

endmodule

// File: rtl/led_mode_sequencer.sv
// ---------------------------------------------------------------------------
// led_mode_sequencer
// LED pattern player with six display modes, stepped by a speed-selectable
// tick. Debounced next/prev buttons cycle the modes in both directions.
// Optional macro BTN_AUTOREPEAT_EN enables button autorepeat in btn_debounce.
// Ports:
//   clk       system clock
//   rst_n     synchronous active-low reset
//   btn_next  raw button, active-high: next mode
//   btn_prev  raw button, active-high: previous mode
//   speed     step period = (CLK_FREQ/2) >> speed cycles
//   leds      registered LED pattern
//   mode      current mode (mode_t encoding)
//   tick      one-cycle pulse on each pattern step
// ---------------------------------------------------------------------------
module led_mode_sequencer
    import led_modes_pkg::*;
#(
    parameter int CLK_FREQ        = 25_000_000,
    parameter int LED_WIDTH       = 8,
    parameter int DEBOUNCE_CYCLES = CLK_FREQ / 50
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 btn_next,
    input  logic                 btn_prev,
    input  logic [1:0]           speed,
    output logic [LED_WIDTH-1:0] leds,
    output logic [2:0]           mode,
    output logic                 tick
);

    localparam int HALF   = CLK_FREQ / 2;
    localparam int TCNT_W = $clog2(HALF + 1);

    logic                 next_p, prev_p;
    logic [TCNT_W-1:0]    tcnt_q, period_c;
    logic                 step_c, tick_c, mode_chg_c;
    mode_t                mode_q, mode_d;
    logic [LED_WIDTH-1:0] leds_q;
    logic                 dir_up_q;
    logic                 tick_q;

    btn_debounce #(
`ifdef BTN_AUTOREPEAT_EN
        .CLK_FREQ        (CLK_FREQ),
`endif
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_next (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .btn_i   (btn_next),
        .press_o (next_p)
    );

    btn_debounce #(
`ifdef BTN_AUTOREPEAT_EN
        .CLK_FREQ        (CLK_FREQ),
`endif
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_prev (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .btn_i   (btn_prev),
        .press_o (prev_p)
    );

    // Opposite presses in the same cycle cancel out.
    assign mode_chg_c = next_p ^ prev_p;

    always_comb begin
        mode_d = mode_q;
        if (next_p && !prev_p)      mode_d = next_mode(mode_q);
        else if (prev_p && !next_p) mode_d = prev_mode(mode_q);
    end

    // Tick generator: >= lets a shortened period take effect immediately.
    assign period_c = TCNT_W'(HALF) >> speed;
    assign step_c   = (tcnt_q >= period_c - TCNT_W'(1));
    assign tick_c   = step_c & ~mode_chg_c;

    always_ff @(posedge clk) begin
        if (!rst_n || mode_chg_c || step_c) tcnt_q <= '0;
        else                                tcnt_q <= tcnt_q + TCNT_W'(1);
    end

    // Mode FSM and pattern datapath; a mode change overrides a coincident step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q   <= SHIFTER;
            leds_q   <= LED_WIDTH'(entry_pattern(SHIFTER, LED_WIDTH));
            dir_up_q <= 1'b1;
            tick_q   <= 1'b0;
        end else begin
            tick_q <= tick_c;
            if (mode_chg_c) begin
                mode_q   <= mode_d;
                leds_q   <= LED_WIDTH'(entry_pattern(mode_d, LED_WIDTH));
                dir_up_q <= 1'b1;
            end else if (tick_c) begin
                unique case (mode_q)
                    SHIFTER, FIVES: leds_q <= {leds_q[LED_WIDTH-2:0], leds_q[LED_WIDTH-1]};
                    COUNTER:        leds_q <= leds_q + LED_WIDTH'(1);
                    BLINK:          leds_q <= ~leds_q;
                    INV_CNT:        leds_q <= leds_q - LED_WIDTH'(1);
                    PINGPONG: begin
                        // Reverse on the tick after reaching an end bit.
                        if (dir_up_q) begin
                            if (leds_q[LED_WIDTH-1]) begin
                                leds_q   <= leds_q >> 1;
                                dir_up_q <= 1'b0;
                            end else begin
                                leds_q <= leds_q << 1;
                            end
                        end else begin
                            if (leds_q[0]) begin
                                leds_q   <= leds_q << 1;
                                dir_up_q <= 1'b1;
                            end else begin
                                leds_q <= leds_q >> 1;
                            end
                        end
                    end
                    default:        leds_q <= leds_q;
                endcase
            end
        end
    end

    assign leds = leds_q;
    assign mode = mode_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_led_mode_sequencer.sv
module tb_led_mode_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_next, btn_prev;
    logic [1:0] speed;
    logic [7:0] leds;
    logic [2:0] mode;
    logic       tick;

    int n_checks = 0;
    int n_fail   = 0;

    led_mode_sequencer #(
        .CLK_FREQ        (64),
        .LED_WIDTH       (8),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_next (btn_next),
        .btn_prev (btn_prev),
        .speed    (speed),
        .leds     (leds),
        .mode     (mode),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Returns cycles until tick is seen, or -1 if the bound expires.
    task automatic wait_tick(output int n);
        n = -1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (tick === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic press(input bit is_next);
        if (is_next) btn_next = 1'b1; else btn_prev = 1'b1;
        step(10);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        step(12);
    endtask

    task automatic goto_mode(input logic [2:0] target);
        for (int i = 0; i < 6; i++) begin
            if (mode == target) break;
            press(1'b1);
        end
    endtask

    task automatic test_reset;
        logic [7:0] exp_l [4] = '{8'h3E, 8'h7C, 8'hF8, 8'hF1};
        int n;
        rst_n = 1'b0; btn_next = 1'b0; btn_prev = 1'b0; speed = 2'd0;
        step(3);
        rst_n = 1'b1;
        n_checks++; if (leds !== 8'h1F) begin n_fail++; $display("FAIL reset_leds: got %h expected 1f", leds); end
        n_checks++; if (mode !== 3'd0) begin n_fail++; $display("FAIL reset_mode: got %0d expected 0", mode); end
        n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", tick); end
        for (int k = 0; k < 4; k++) begin
            wait_tick(n);
            n_checks++; if (n !== ((k == 0) ? 32 : 31)) begin n_fail++; $display("FAIL shifter_period[%0d]: got %0d expected %0d", k, n, (k == 0) ? 32 : 31); end
            n_checks++; if (leds !== exp_l[k]) begin n_fail++; $display("FAIL shifter_leds[%0d]: got %h expected %h", k, leds, exp_l[k]); end
            step(1);
            n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL tick_width[%0d]: got %b expected 0", k, tick); end
        end
    endtask

    task automatic test_debounce;
        btn_next = 1'b1; step(3); btn_next = 1'b0; step(15);
        n_checks++; if (mode !== 3'd0) begin n_fail++; $display("FAIL glitch_ignored: got mode %0d expected 0", mode); end
        press(1'b1);
        step(5);
        n_checks++; if (mode !== 3'd1) begin n_fail++; $display("FAIL held_press_mode: got %0d expected 1", mode); end
        n_checks++; if (leds !== 8'h00) begin n_fail++; $display("FAIL held_press_leds: got %h expected 00", leds); end
    endtask

    task automatic test_mode_cycle;
        logic [2:0] exp_m [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        logic [7:0] exp_l [6] = '{8'h00, 8'h55, 8'hFF, 8'hFF, 8'h01, 8'h1F};
        goto_mode(3'd0);
        for (int k = 0; k < 6; k++) begin
            press(1'b1);
            n_checks++; if (mode !== exp_m[k]) begin n_fail++; $display("FAIL next_mode[%0d]: got %0d expected %0d", k, mode, exp_m[k]); end
            n_checks++; if (leds !== exp_l[k]) begin n_fail++; $display("FAIL next_entry[%0d]: got %h expected %h", k, leds, exp_l[k]); end
        end
        press(1'b0);
        n_checks++; if (mode !== 3'd5) begin n_fail++; $display("FAIL prev_wrap_mode: got %0d expected 5", mode); end
        n_checks++; if (leds !== 8'h01) begin n_fail++; $display("FAIL prev_wrap_leds: got %h expected 01", leds); end
    endtask

    task automatic test_counters;
        logic [7:0] exp_pp [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40};
        int n;
        goto_mode(3'd4);
        n_checks++; if (leds !== 8'hFF) begin n_fail++; $display("FAIL inv_entry: got %h expected ff", leds); end
        wait_tick(n);
        n_checks++; if (leds !== 8'hFE) begin n_fail++; $display("FAIL inv_step1: got %h expected fe", leds); end
        wait_tick(n);
        n_checks++; if (leds !== 8'hFD) begin n_fail++; $display("FAIL inv_step2: got %h expected fd", leds); end
        goto_mode(3'd1);
        n_checks++; if (leds !== 8'h00) begin n_fail++; $display("FAIL cnt_entry: got %h expected 00", leds); end
        speed = 2'd3;
        for (int k = 0; k < 255; k++) wait_tick(n);
        n_checks++; if (leds !== 8'hFF) begin n_fail++; $display("FAIL cnt_255: got %h expected ff", leds); end
        wait_tick(n);
        n_checks++; if (leds !== 8'h00) begin n_fail++; $display("FAIL cnt_wrap: got %h expected 00", leds); end
        speed = 2'd0;
        goto_mode(3'd5);
        n_checks++; if (leds !== 8'h01) begin n_fail++; $display("FAIL pp_entry: got %h expected 01", leds); end
        for (int k = 0; k < 8; k++) begin
            wait_tick(n);
            n_checks++; if (leds !== exp_pp[k]) begin n_fail++; $display("FAIL pingpong[%0d]: got %h expected %h", k, leds, exp_pp[k]); end
        end
    endtask

    task automatic test_speed_and_collisions;
        int n;
        int chg_at;
        logic [2:0] prev_m;
        speed = 2'd3;
        wait_tick(n);
        wait_tick(n);
        n_checks++; if (n !== 4) begin n_fail++; $display("FAIL speed3_period: got %0d expected 4", n); end
        step(2);
        speed = 2'd0;
        wait_tick(n);
        n_checks++; if (n !== 30) begin n_fail++; $display("FAIL speed_switch: got %0d expected 30", n); end
        btn_next = 1'b1; btn_prev = 1'b1;
        step(10);
        btn_next = 1'b0; btn_prev = 1'b0;
        step(12);
        n_checks++; if (mode !== 3'd5) begin n_fail++; $display("FAIL next_prev_cancel: got %0d expected 5", mode); end
        // Align a press so its mode change lands on a tick cycle (period 4).
        speed = 2'd3;
        wait_tick(n);
        btn_next = 1'b1;
        prev_m = mode;
        chg_at = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (mode !== prev_m && chg_at < 0) begin
                chg_at = i;
                n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL press_tick_collision: got tick %b expected 0", tick); end
            end
        end
        n_checks++; if (chg_at !== 8) begin n_fail++; $display("FAIL press_latency: got %0d expected 8", chg_at); end
        n_checks++; if (mode !== 3'd0) begin n_fail++; $display("FAIL collision_mode: got %0d expected 0", mode); end
        speed = 2'd0;
        btn_next = 1'b0;
        step(12);
    endtask

    task automatic test_reset_mid_press;
        goto_mode(3'd3);
        n_checks++; if (mode !== 3'd3) begin n_fail++; $display("FAIL reach_blink: got %0d expected 3", mode); end
        btn_next = 1'b1;
        step(3);
        rst_n = 1'b0; btn_next = 1'b0;
        step(1);
        rst_n = 1'b1;
        n_checks++; if (mode !== 3'd0) begin n_fail++; $display("FAIL midrst_mode: got %0d expected 0", mode); end
        n_checks++; if (leds !== 8'h1F) begin n_fail++; $display("FAIL midrst_leds: got %h expected 1f", leds); end
        step(20);
        n_checks++; if (mode !== 3'd0) begin n_fail++; $display("FAIL midrst_no_pending: got %0d expected 0", mode); end
        n_checks++; if (leds !== 8'h1F) begin n_fail++; $display("FAIL midrst_leds_hold: got %h expected 1f", leds); end
    endtask

`ifdef BTN_AUTOREPEAT_EN
    task automatic test_autorepeat;
        int t_chg [$];
        logic [2:0] prev_m;
        prev_m = mode;
        btn_next = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            if (i == 201) btn_next = 1'b0;
            @(negedge clk);
            if (mode !== prev_m) begin
                t_chg.push_back(i);
                prev_m = mode;
            end
        end
        n_checks++; if (t_chg.size() < 8) begin n_fail++; $display("FAIL repeat_count: got %0d expected >= 8", t_chg.size()); end
        for (int k = 1; k < t_chg.size(); k++) begin
            n_checks++;
            if (t_chg[k] - t_chg[k-1] !== ((k == 1) ? 64 : 16)) begin
                n_fail++;
                $display("FAIL repeat_gap[%0d]: got %0d expected %0d", k, t_chg[k] - t_chg[k-1], (k == 1) ? 64 : 16);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_debounce();
        test_mode_cycle();
        test_counters();
        test_speed_and_collisions();
        test_reset_mid_press();
`ifdef BTN_AUTOREPEAT_EN
        test_autorepeat();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
